// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the byte width carried from requesters to the transmitter.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [1:0] TXA_IDLE  = 2'd0;
    localparam logic [1:0] TXA_START = 2'd1;
    localparam logic [1:0] TXA_WAIT  = 2'd2;
    localparam logic [1:0] TXA_GAP   = 2'd3;

    // Width of a counter that must hold 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first set request strictly after 'last',
// wrapping modulo NREQ. The pointer register lives in the caller.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    logic [IW-1:0] w_idx;

    // Scan farthest-first so the nearest requester after 'last' overrides.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IW'((int'(last) + k) % NREQ);
            if (req[w_idx]) begin
                gnt        = '0;
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NREQ byte requesters, with
// start-acknowledge timeout, enforced inter-frame gap and a completed-frame count.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int ACK_TIMEOUT = 16,
    parameter  int GAP_CYCLES  = 2,
    localparam int IW          = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]      txdata,
    output logic                        txstart,
    input  logic                        tx_busy,
    output logic [IW-1:0]               grant_id,
    output logic                        active,
    output logic                        err_timeout,
    output logic [15:0]                 frame_cnt
);

    localparam int TW = cnt_w(ACK_TIMEOUT);
    localparam int GW = cnt_w(GAP_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [1:0]    POST_ST  = (GAP_CYCLES == 0) ? TXA_IDLE : TXA_GAP;

    logic [1:0]             r_state;
    logic [1:0]             w_next;
    logic [IW-1:0]          r_last;
    logic [IW-1:0]          r_grant_id;
    logic [UART_BYTE_W-1:0] r_txdata;
    logic [TW-1:0]          r_tmo_cnt;
    logic [GW-1:0]          r_gap_cnt;
    logic                   r_err;
    logic [15:0]            r_frame_cnt;

    logic [NREQ-1:0]        w_gnt;
    logic [IW-1:0]          w_gnt_idx;
    logic                   w_any;
    logic [UART_BYTE_W-1:0] w_sel_byte;
    logic                   w_can_grant;
    logic                   w_tmo_hit;
    logic                   w_gap_end;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req_valid),
        .last    (r_last),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_gnt[i]) w_sel_byte = req_data[UART_BYTE_W*i +: UART_BYTE_W];
    end

    // A transmitter still busy from elsewhere blocks new grants.
    assign w_can_grant = w_any && !tx_busy;
    assign w_tmo_hit   = !tx_busy && (r_tmo_cnt == TMO_LAST);
    assign w_gap_end   = (r_gap_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= TXA_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TXA_IDLE:  if (w_can_grant) w_next = TXA_START;
            TXA_START: begin
                if (tx_busy)        w_next = TXA_WAIT;
                else if (w_tmo_hit) w_next = POST_ST;
            end
            TXA_WAIT:  if (!tx_busy) w_next = POST_ST;
            TXA_GAP:   if (w_gap_end) w_next = TXA_IDLE;
            default:   w_next = TXA_IDLE;
        endcase
    end

    // req_ready is gated by rst so every output reads zero while held in reset.
    always_comb begin
        txstart   = 1'b0;
        active    = 1'b0;
        req_ready = '0;
        case (r_state)
            TXA_IDLE:  if (rst && !tx_busy) req_ready = w_gnt;
            TXA_START: begin
                txstart = 1'b1;
                active  = 1'b1;
            end
            TXA_WAIT:  active = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last      <= IW'(NREQ - 1);
            r_grant_id  <= '0;
            r_txdata    <= '0;
            r_tmo_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                TXA_IDLE: begin
                    if (w_can_grant) begin
                        r_txdata   <= w_sel_byte;
                        r_grant_id <= w_gnt_idx;
                        r_last     <= w_gnt_idx;
                        r_tmo_cnt  <= '0;
                    end
                end
                TXA_START: begin
                    r_gap_cnt <= '0;
                    if (!tx_busy) begin
                        if (w_tmo_hit) r_err     <= 1'b1;
                        else           r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                TXA_WAIT: begin
                    r_gap_cnt <= '0;
                    if (!tx_busy) r_frame_cnt <= r_frame_cnt + 16'd1;
                end
                default: r_gap_cnt <= r_gap_cnt + 1'b1;
            endcase
        end
    end

    assign txdata      = r_txdata;
    assign grant_id    = r_grant_id;
    assign err_timeout = r_err;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-timestamp reference model
// and a simple transmitter model that answers txstart with a busy pulse.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int ACK  = 16;
    localparam int GAP  = 2;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        txdata;
    logic              txstart;
    logic              tx_busy   = 1'b0;
    logic [1:0]        grant_id;
    logic              active;
    logic              err_timeout;
    logic [15:0]       frame_cnt;

    uart_tx_arbiter #(.NREQ(NREQ), .ACK_TIMEOUT(ACK), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .txdata      (txdata),
        .txstart     (txstart),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, expressed as timestamps of frame events.
    int          cyc = 0;
    bit          in_frame, seen_busy, deaf, hold, force_deaf, ext_busy;
    int          g_cyc, b_cyc, tmo_cyc, elig_from, m_last, m_gid, rise, len;
    int          fixed_len = 0, p_deaf = 0, n_mgr = 0, last_fall = 0;
    logic [7:0]  m_byte;
    logic [15:0] m_fcnt;
    logic [NREQ-1:0] pend = '0;
    logic [7:0]  pbyte [NREQ];

    // Observations of the DUT itself.
    int dut_grants[$];
    int dut_gaps[$];
    int n_ts = 0, n_errpulse = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        in_frame  = 0;
        seen_busy = 0;
        m_last    = NREQ - 1;
        m_gid     = 0;
        m_byte    = '0;
        m_fcnt    = '0;
        elig_from = 0;
        tmo_cyc   = -100;
        g_cyc     = 0;
    endtask

    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        bit elig;
        int w;
        @(negedge clk);
        cyc++;
        tx_busy   = in_frame ? (!deaf && cyc >= rise && cyc < rise + len) : ext_busy;
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = pbyte[i];
        #1;
        elig    = !in_frame && cyc >= elig_from && !tx_busy;
        exp_rdy = '0;
        w       = -1;
        if (elig && pend != '0) begin
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && pend[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            exp_rdy[w] = 1'b1;
        end
        chk("req_ready",   req_ready,   exp_rdy);
        chk("txstart",     txstart,     in_frame && cyc > g_cyc && !seen_busy);
        chk("active",      active,      in_frame && cyc > g_cyc);
        chk("err_timeout", err_timeout, cyc == tmo_cyc + 1);
        chk("frame_cnt",   frame_cnt,   m_fcnt);
        chk("grant_id",    grant_id,    m_gid);
        if (in_frame && cyc > g_cyc) chk("txdata", txdata, m_byte);

        if (req_ready != '0) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_grants.push_back(i);
            dut_gaps.push_back(cyc - last_fall);
            n_ts = 0;
        end
        if (txstart) n_ts++;
        if (err_timeout) n_errpulse++;

        if (in_frame && cyc > g_cyc) begin
            if (!seen_busy) begin
                if (tx_busy) begin
                    seen_busy = 1;
                    b_cyc     = cyc;
                end else if (cyc == g_cyc + ACK) begin
                    tmo_cyc   = cyc;
                    in_frame  = 0;
                    elig_from = cyc + 1 + GAP;
                end
            end else if (!tx_busy) begin
                m_fcnt    = m_fcnt + 16'd1;
                in_frame  = 0;
                last_fall = cyc;
                elig_from = cyc + 1 + GAP;
            end
        end
        if (w >= 0) begin
            in_frame  = 1;
            seen_busy = 0;
            g_cyc     = cyc;
            m_last    = w;
            m_gid     = w;
            m_byte    = pbyte[w];
            n_mgr++;
            deaf = force_deaf || (int'($urandom_range(0, 99)) < p_deaf);
            rise = cyc + 1 + int'($urandom_range(0, 3));
            len  = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 5));
            if (!hold) pend[w] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        pend      = '0;
        req_valid = '0;
        ext_busy  = 0;
        tx_busy   = 1'b0;
        #1;
        chk("rst_txstart", txstart,     0);
        chk("rst_active",  active,      0);
        chk("rst_ready",   req_ready,   0);
        chk("rst_fcnt",    frame_cnt,   0);
        chk("rst_err",     err_timeout, 0);
        chk("rst_gid",     grant_id,    0);
        chk("rst_txdata",  txdata,      0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_reset();
    endtask

    task automatic run_until(input int target, input int maxc);
        int c = 0;
        while ((n_mgr < target || in_frame) && c < maxc) begin
            step();
            c++;
        end
        chk("run_bound", n_mgr >= target && !in_frame, 1);
    endtask

    task automatic rnd_stim();
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
                pend[i]  = 1'b1;
                pbyte[i] = 8'($urandom);
            end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                pend[i] = 1'b0;
            end
        end
        ext_busy = !in_frame && ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        int base;
        int c;
        for (int i = 0; i < NREQ; i++) pbyte[i] = '0;
        hold = 0;
        force_deaf = 0;
        m_reset();
        do_reset();

        // 1: single requester, byte A5
        pend = 4'b0001;
        pbyte[0] = 8'hA5;
        base = dut_grants.size();
        run_until(n_mgr + 1, 100);
        repeat (GAP + 1) step();
        chk("t1_grant", dut_grants.size() > base ? dut_grants[base] : -1, 0);
        chk("t1_count", dut_grants.size() - base, 1);
        chk("t1_fcnt",  frame_cnt, 1);

        // 2: all four held; strict rotation and fixed gap
        do_reset();
        hold = 1;
        for (int i = 0; i < NREQ; i++) pbyte[i] = 8'(8'h10 + i);
        pend = 4'b1111;
        base = dut_grants.size();
        run_until(n_mgr + 5, 200);
        hold = 0;
        pend = '0;
        for (int i = 0; i < 5; i++)
            chk("t2_order", dut_grants.size() > base + i ? dut_grants[base + i] : -1, i % NREQ);
        for (int i = 1; i < 5; i++)
            chk("t2_gap", dut_gaps.size() > base + i ? dut_gaps[base + i] : -1, GAP + 1);

        // 3: transmitter never acknowledges
        force_deaf = 1;
        n_errpulse = 0;
        pend = 4'b0001;
        pbyte[0] = 8'h3C;
        run_until(n_mgr + 1, 100);
        force_deaf = 0;
        repeat (GAP + 1) step();
        chk("t3_txstart_cycles", n_ts, ACK);
        chk("t3_err_pulses",     n_errpulse, 1);
        chk("t3_fcnt",           frame_cnt, 5);
        pend = 4'b0100;
        pbyte[2] = 8'hC3;
        base = dut_grants.size();
        run_until(n_mgr + 1, 100);
        repeat (GAP + 1) step();
        chk("t3_next_grant", dut_grants.size() > base ? dut_grants[base] : -1, 2);
        chk("t3_fcnt_after", frame_cnt, 6);

        // 4: reset while waiting for the frame to finish
        fixed_len = 20;
        pend = 4'b0001;
        pbyte[0] = 8'h5A;
        c = 0;
        while (!(in_frame && seen_busy && cyc > b_cyc) && c < 50) begin
            step();
            c++;
        end
        chk("t4_in_wait", in_frame && seen_busy, 1);
        chk("t4_active_before", active, 1);
        do_reset();
        fixed_len = 0;
        pend = 4'b1111;
        for (int i = 0; i < NREQ; i++) pbyte[i] = 8'(8'h40 + i);
        base = dut_grants.size();
        run_until(n_mgr + 1, 100);
        pend = '0;
        chk("t4_first", dut_grants.size() > base ? dut_grants[base] : -1, 0);

        // 5: pointer at 1 with 1010 pending; glitch during gap
        do_reset();
        pend = 4'b0011;
        run_until(n_mgr + 2, 100);
        pend = 4'b1010;
        pbyte[1] = 8'h11;
        pbyte[3] = 8'h33;
        base = dut_grants.size();
        run_until(n_mgr + 1, 100);
        pend[0] = 1'b1;
        step();
        chk("t5_glitch", req_ready, 0);
        pend[0] = 1'b0;
        run_until(n_mgr + 1, 100);
        chk("t5_first",  dut_grants.size() > base     ? dut_grants[base]     : -1, 3);
        chk("t5_second", dut_grants.size() > base + 1 ? dut_grants[base + 1] : -1, 1);

        // 6: frame counter wrap
        do_reset();
        @(negedge clk);
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        m_fcnt = 16'hFFFF;
        pend = 4'b0010;
        pbyte[1] = 8'hEE;
        run_until(n_mgr + 1, 100);
        repeat (GAP + 1) step();
        chk("t6_wrap", frame_cnt, 0);

        // Random traffic with drops, foreign busy and occasional deaf transmitter
        p_deaf = 15;
        for (int i = 0; i < 800; i++) begin
            rnd_stim();
            step();
        end
        pend = '0;
        ext_busy = 0;
        p_deaf = 0;
        run_until(n_mgr, 200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
